// File: rtl/piso_pkg.sv
// Shared state encoding and defaults for the PISO shift-register controller.
package piso_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 0;
    localparam int FCOUNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/piso_ctrl_if.sv
// Upstream word handshake plus the control/status bundle of the PISO controller.
interface piso_ctrl_if
    import piso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                abort;
    logic                piso_control;
    logic                piso_clear;
    logic [WIDTH-1:0]    piso_data;
    logic                ser_valid;
    logic                ser_first;
    logic                ser_last;
    logic                busy;
    logic [FCOUNT_W-1:0] frame_count;
    state_t              dbg_state;

    // Handshake: a word moves on a rising edge where in_valid && in_ready are both 1;
    // the source keeps in_data stable while in_valid is high and in_ready is low.
    modport master (
        output in_valid, in_data, abort,
        input  in_ready, piso_control, piso_clear, piso_data,
        input  ser_valid, ser_first, ser_last, busy, frame_count, dbg_state
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, piso_control, piso_clear, piso_data,
        output ser_valid, ser_first, ser_last, busy, frame_count, dbg_state
    );

endinterface

// File: rtl/piso_ctrl_buf.sv
// One-entry holding buffer between the upstream handshake and the frame launcher.
module piso_ctrl_buf
    import piso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    // push only happens while empty and pop only while full, so they never coincide
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_ctrl.sv
// Sequences load/shift/gap control for an external PISO register and flags the serial frame bits.
module piso_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic       clk,
    input  logic       clear_n,
    piso_ctrl_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [4:0]       GAP_LEN  = 5'(GAP);

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [3:0]          gap_cnt;
    logic                trail;
    logic                clr_q;
    logic                buf_full;
    logic                push;
    logic                launch;
    logic                last_shift;
    logic                last_gap;
    logic [WIDTH-1:0]    buf_data;
    logic [WIDTH-1:0]    data_q;
    logic [FCOUNT_W-1:0] fcount;

    assign bus.in_ready = clear_n & ~buf_full;
    assign push         = bus.in_valid & bus.in_ready;
    assign launch       = (next_state == ST_LOAD);
    assign last_shift   = (bit_cnt == CNT_LAST);
    assign last_gap     = (({1'b0, gap_cnt} + 5'd1) == GAP_LEN);

    piso_ctrl_buf #(.WIDTH(WIDTH)) u_buf (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (push),
        .pop     (launch),
        .din     (bus.in_data),
        .full    (buf_full),
        .dout    (buf_data)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // abort overrides every transition, so a killed frame never pops the buffer
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (buf_full) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (last_shift) begin
                    if (GAP == 0) next_state = buf_full ? ST_LOAD : ST_IDLE;
                    else          next_state = ST_GAP;
                end
            end
            ST_GAP:   if (last_gap) next_state = buf_full ? ST_LOAD : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (bus.abort) next_state = ST_IDLE;
    end

    // trail marks the cycle after the last shift, when the final bit sits on the serial pin
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
            trail   <= 1'b0;
            clr_q   <= 1'b1;
            data_q  <= '0;
            fcount  <= '0;
        end else begin
            clr_q <= bus.abort;
            trail <= (state == ST_SHIFT) && last_shift && !bus.abort;
            if (next_state == ST_SHIFT)
                bit_cnt <= (state == ST_SHIFT) ? bit_cnt + 1'b1 : CNT_W'(1);
            else
                bit_cnt <= '0;
            if ((next_state == ST_GAP) && (state == ST_GAP)) gap_cnt <= gap_cnt + 1'b1;
            else                                              gap_cnt <= '0;
            if (launch)           data_q <= buf_data;
            if (trail && !bus.abort) fcount <= fcount + 1'b1;
        end
    end

    always_comb begin
        bus.piso_control = (state == ST_SHIFT);
        bus.ser_valid    = (state == ST_SHIFT) || trail;
        bus.ser_first    = (state == ST_SHIFT) && (bit_cnt == CNT_W'(1));
        bus.ser_last     = trail;
        bus.busy         = (state != ST_IDLE);
    end

    assign bus.piso_clear  = clr_q;
    assign bus.piso_data   = data_q;
    assign bus.frame_count = fcount;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_piso_ctrl.sv
// Directed bench: a GAP=0 and a GAP=2 controller; the GAP=0 one drives a behavioural 4-bit PISO register.
module tb_piso_ctrl;
    import piso_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear_n;
    int           n_checks = 0;
    int           n_pass = 0;
    logic         exp_q[$];
    logic [W-1:0] sr0;
    logic         ser0;
    logic [4:0]   t1_exp [6];
    int           sv_cnt, first_sv, last_sv, fl, sf, zeros;
    logic [11:0]  ctl_pat;

    piso_ctrl_if #(.WIDTH(W)) b0 ();
    piso_ctrl_if #(.WIDTH(W)) b2 ();

    piso_ctrl #(.WIDTH(W), .GAP(0)) dut0 (.clk(clk), .clear_n(clear_n), .bus(b0));
    piso_ctrl #(.WIDTH(W), .GAP(2)) dut2 (.clk(clk), .clear_n(clear_n), .bus(b2));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    // 4-bit PISO register: MSB is the serial pin, shifts toward it
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n)               sr0 <= '0;
        else if (b0.piso_clear)     sr0 <= '0;
        else if (!b0.piso_control)  sr0 <= b0.piso_data;
        else                        sr0 <= {sr0[W-2:0], 1'b0};
    end
    assign ser0 = sr0[W-1];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (clear_n && b0.ser_valid) begin
            if (exp_q.size() == 0) check("ser_extra", 16'(b0.ser_valid), 16'd0);
            else                   check("ser_bit", 16'(ser0), 16'(exp_q.pop_front()));
        end
    end

    task automatic expect_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic push(input bit g2, input logic [W-1:0] w);
        int n = 0;
        if (g2) begin b2.in_valid = 1'b1; b2.in_data = w; end
        else    begin b0.in_valid = 1'b1; b0.in_data = w; end
        while (!(g2 ? b2.in_ready : b0.in_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("push_timeout", 16'(n), 16'd0);
        @(negedge clk);
        if (g2) b2.in_valid = 1'b0;
        else    b0.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((b0.busy || b0.ser_valid || !b0.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 16'(n < 200), 16'd1);
    endtask

    initial begin
        t1_exp = '{5'b00001, 5'b11101, 5'b11001, 5'b11001, 5'b01010, 5'b00000};
        clear_n     = 1'b0;
        b0.in_valid = 1'b0; b0.in_data = '0; b0.abort = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.abort = 1'b0;
        repeat (2) @(negedge clk);

        // reset values
        check("rst_clear", 16'(b0.piso_clear), 16'd1);
        check("rst_ready", 16'(b0.in_ready), 16'd0);
        check("rst_outs", 16'({b0.piso_control, b0.ser_valid, b0.ser_first, b0.ser_last, b0.busy}), 16'd0);
        check("rst_data", 16'(b0.piso_data), 16'd0);
        check("rst_fcount", 16'(b0.frame_count), 16'd0);
        check("rst_state", 16'(b0.dbg_state), 16'(ST_IDLE));
        #2 clear_n = 1'b1;
        #1 check("rel_clear_hold", 16'(b0.piso_clear), 16'd1);
        check("rel_ready", 16'(b0.in_ready), 16'd1);
        @(negedge clk);
        check("rel_clear_drop", 16'(b0.piso_clear), 16'd0);

        // single word 1011: per-cycle {control, ser_valid, first, last, busy} from L
        expect_word(4'b1011);
        push(1'b0, 4'b1011);
        check("t1_wait_state", 16'(b0.dbg_state), 16'(ST_IDLE));
        check("t1_buf_full", 16'(b0.in_ready), 16'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t1_ctl", 16'({b0.piso_control, b0.ser_valid, b0.ser_first, b0.ser_last, b0.busy}),
                  16'(t1_exp[i]));
            if (i == 0 || i == 5) check("t1_data", 16'(b0.piso_data), 16'hB);
        end
        check("t1_fcount", 16'(b0.frame_count), 16'd1);
        check("t1_drain", 16'(exp_q.size()), 16'd0);

        // back-to-back A, 5, F
        expect_word(4'hA); expect_word(4'h5); expect_word(4'hF);
        fork
            begin push(1'b0, 4'hA); push(1'b0, 4'h5); push(1'b0, 4'hF); end
        join_none
        sv_cnt = 0; first_sv = -1; last_sv = -1; ctl_pat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b0.ser_valid) begin
                sv_cnt++;
                if (first_sv < 0) first_sv = i;
                last_sv = i;
            end
            if (i >= 1 && i <= 12) ctl_pat = {ctl_pat[10:0], b0.piso_control};
        end
        check("t2_sv_count", 16'(sv_cnt), 16'd12);
        check("t2_sv_first", 16'(first_sv), 16'd2);
        check("t2_sv_last", 16'(last_sv), 16'd13);
        check("t2_ctl_pattern", 16'(ctl_pat), 16'h777);
        check("t2_fcount", 16'(b0.frame_count), 16'd4);
        check("t2_drain", 16'(exp_q.size()), 16'd0);

        // GAP=2 instance, two queued words
        fork
            begin push(1'b1, 4'h3); push(1'b1, 4'hC); end
        join_none
        fl = -1; sf = -1; zeros = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (b2.ser_last && fl < 0) fl = i;
            if (b2.ser_first && fl >= 0 && sf < 0) sf = i;
            if (fl >= 0 && sf < 0 && !b2.ser_valid) zeros++;
            if (i == 6) check("t3_gap_outs", 16'({b2.busy, b2.piso_control, b2.ser_valid}), 16'b100);
        end
        check("t3_gap_zeros", 16'(zeros), 16'd2);
        check("t3_last_to_first", 16'(sf - fl), 16'd3);
        check("t3_fcount", 16'(b2.frame_count), 16'd2);

        // abort at L+2 with a second word buffered
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        expect_word(4'h9);
        push(1'b0, 4'hC);
        push(1'b0, 4'h9);
        check("t4_first", 16'(b0.ser_first), 16'd1);
        @(negedge clk);
        b0.abort = 1'b1;
        @(negedge clk);
        b0.abort = 1'b0;
        check("t4_abort_outs", 16'({b0.piso_clear, b0.piso_control, b0.ser_valid, b0.busy}), 16'b1000);
        check("t4_state", 16'(b0.dbg_state), 16'(ST_IDLE));
        check("t4_buf_kept", 16'(b0.in_ready), 16'd0);
        check("t4_fcount_hold", 16'(b0.frame_count), 16'd4);
        @(negedge clk);
        check("t4_clear_pulse", 16'(b0.piso_clear), 16'd0);
        check("t4_relaunch", 16'(b0.dbg_state), 16'(ST_LOAD));
        check("t4_data", 16'(b0.piso_data), 16'h9);
        wait_idle("t4_idle");
        check("t4_fcount", 16'(b0.frame_count), 16'd5);
        check("t4_drain", 16'(exp_q.size()), 16'd0);

        // reset during SHIFT with a word buffered
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        push(1'b0, 4'h3);
        push(1'b0, 4'h6);
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1 check("t5_outs", 16'({b0.piso_clear, b0.piso_control, b0.ser_valid, b0.ser_first,
                                b0.ser_last, b0.busy}), 16'b100000);
        check("t5_ready", 16'(b0.in_ready), 16'd0);
        check("t5_data", 16'(b0.piso_data), 16'd0);
        check("t5_fcount", 16'(b0.frame_count), 16'd0);
        check("t5_state", 16'(b0.dbg_state), 16'(ST_IDLE));
        @(negedge clk);
        check("t5_clear_held", 16'(b0.piso_clear), 16'd1);
        #2 clear_n = 1'b1;
        #1 check("t5_clear_after_rel", 16'(b0.piso_clear), 16'd1);
        @(negedge clk);
        check("t5_clear_drop", 16'(b0.piso_clear), 16'd0);
        check("t5_buf_dropped", 16'(b0.in_ready), 16'd1);
        repeat (8) @(negedge clk);
        check("t5_no_frame", 16'({b0.busy, b0.frame_count}), 16'd0);
        check("t5_drain", 16'(exp_q.size()), 16'd0);

        // frame_count wrap
        for (int i = 0; i < 255; i++) expect_word(4'(i));
        for (int i = 0; i < 255; i++) push(1'b0, 4'(i));
        wait_idle("t6_idle_a");
        check("t6_fcount_255", 16'(b0.frame_count), 16'd255);
        expect_word(4'h7);
        push(1'b0, 4'h7);
        wait_idle("t6_idle_b");
        check("t6_fcount_wrap", 16'(b0.frame_count), 16'd0);
        check("t6_drain", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
